program_counter: RTL and testbench
==================================

# program_counter

Holds the CPU's 16-bit program counter (PCL/PCH) and the address bus output registers (ABL/ABH). The block consumes the Address Low Bus value `ADL` and the Address High Bus value `ADH`, increments the program counter with a carry from low byte to high byte, and drives `Program_Counter_Low_Register_Out` back into the Address Low Bus mux. ABL/ABH form the external address presented to memory.

## Interface
- No parameters. Widths are fixed by the 6502 datapath.
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ADL` in 8: Address Low Bus value, combinational from the bus mux in the same cycle.
- `ADH` in 8: Address High Bus value.
- `ADL_PCL` in 1: select `ADL` as the PCL source (PCLS mux).
- `ADH_PCH` in 1: select `ADH` as the PCH source.
- `I_PC` in 1: increment the selected PC value this cycle.
- `ADL_ABL` in 1: load ABL from `ADL`.
- `ADH_ABH` in 1: load ABH from `ADH`.
- `Program_Counter_Low_Register_Out` out 8: registered PCL.
- `Program_Counter_High_Register_Out` out 8: registered PCH.
- `ABL` out 8: registered address bus low byte.
- `ABH` out 8: registered address bus high byte.
- `PC_Carry` out 1: registered carry out of the PCL increment from the last update.

## Operation
- PCL source select (PCLS): `ADL` if `ADL_PCL`, else current PCL.
- PCH source select (PCHS): `ADH` if `ADH_PCH`, else current PCH.
- Increment:
  - `{c, PCLnext} = PCLS + I_PC`, as a 9-bit sum.
  - `PCHnext = PCHS + c`, as an 8-bit sum that wraps.
  - The carry is generated only when `I_PC`=1 and PCLS=0xFF.
- Every cycle, PCL ← PCLnext, PCH ← PCHnext, and `PC_Carry` ← c. PC is loaded and incremented in the same cycle when a select and `I_PC` are both active.
- With no select and no `I_PC`, PC holds.
- ABL ← `ADL` when `ADL_ABL`, else holds. ABH ← `ADH` when `ADH_ABH`, else holds. ABL and ABH are independent of the PC registers.
- Wrap-around: PC=0xFFFF with `I_PC` gives PC=0x0000 and `PC_Carry`=1.
- Load of 0xFF from `ADL` with `I_PC` gives PCL=0x00 and increments the PCH source. The PCH source is `ADH` if `ADH_PCH`, else the old PCH.
- Simultaneous `ADL_PCL` and `ADL_ABL`: both load the same `ADL` value. ABL receives the pre-increment value.
- Reset values: PCL=0x00, PCH=0x00, ABL=0x00, ABH=0x00, `PC_Carry`=0. Reset overrides all control inputs in the same cycle.
- Reset asserted mid-sequence: all state returns to the reset values on that edge. No partial increment is retained.
- All outputs come directly from flops. No combinational path from inputs to outputs.

## Timing
- Latency is one cycle. Controls and buses sampled at edge N appear on the outputs after edge N.
- `Program_Counter_Low_Register_Out` is stable for the whole cycle. The Address Low Bus mux can therefore place PCL on `ADL` and this block can load ABL from that `ADL` in the same cycle. This gives the standard fetch pattern: ABL=PCL while PC increments, with ABL showing the old PC and PC advanced by 1 one cycle later.
- Back-to-back `I_PC` cycles advance PC by 1 per cycle with no bubbles.
- The carry ripples PCL→PCH within a single cycle. No extra cycle is needed for page crossing.

## Test plan
- Reset: assert `rst` with all controls high and `ADL`=0xAA, `ADH`=0x55 → all outputs 0x00 and `PC_Carry`=0 after the edge.
- Load and increment: `ADL`=0x34, `ADH`=0x12, `ADL_PCL`=`ADH_PCH`=1, `I_PC`=0 for one cycle; then only `I_PC`=1 for 3 cycles → PC=0x1234, 0x1235, 0x1236, 0x1237.
- Page cross: PC=0x12FF, `I_PC`=1 → PC=0x1300 and `PC_Carry`=1; next idle cycle → PC holds 0x1300 and `PC_Carry`=0.
- Full wrap: PC=0xFFFF, `I_PC`=1 → PC=0x0000 and `PC_Carry`=1.
- Fetch overlap: PC=0x8000; `ADL`=0x00 (PCL on ADL), `ADH`=0x80, `ADL_ABL`=`ADH_ABH`=`I_PC`=1 → ABL/ABH=0x00/0x80 and PC=0x8001 after the same edge.
- Load and increment in one cycle with reset mid-sequence: `ADL`=0xFF, `ADH`=0x20, both selects and `I_PC`=1 → PC=0x2100. Next cycle `rst`=1 with `I_PC`=1 → PC=0x0000.

Source files
------------

// File: rtl/program_counter.sv
// 16-bit program counter (PCL/PCH) with address bus output registers (ABL/ABH).
// Latency 1 cycle; no backpressure, all state updates every cycle.
module program_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ADL,
    input  logic [7:0] ADH,
    input  logic       ADL_PCL,
    input  logic       ADH_PCH,
    input  logic       I_PC,
    input  logic       ADL_ABL,
    input  logic       ADH_ABH,
    output logic [7:0] Program_Counter_Low_Register_Out,
    output logic [7:0] Program_Counter_High_Register_Out,
    output logic [7:0] ABL,
    output logic [7:0] ABH,
    output logic       PC_Carry
);

    logic [7:0] pcl_q, pcl_d;
    logic [7:0] pch_q, pch_d;
    logic [7:0] abl_q, abl_d;
    logic [7:0] abh_q, abh_d;
    logic       carry_q, carry_d;
    logic [7:0] pcl_src;
    logic [7:0] pch_src;

    always_comb begin
        pcl_src = ADL_PCL ? ADL : pcl_q;
        pch_src = ADH_PCH ? ADH : pch_q;
        // Low-byte carry ripples into the high byte in the same cycle.
        {carry_d, pcl_d} = {1'b0, pcl_src} + {8'h00, I_PC};
        pch_d = pch_src + {7'h00, carry_d};
        abl_d = ADL_ABL ? ADL : abl_q;
        abh_d = ADH_ABH ? ADH : abh_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcl_q   <= 8'h00;
            pch_q   <= 8'h00;
            abl_q   <= 8'h00;
            abh_q   <= 8'h00;
            carry_q <= 1'b0;
        end else begin
            pcl_q   <= pcl_d;
            pch_q   <= pch_d;
            abl_q   <= abl_d;
            abh_q   <= abh_d;
            carry_q <= carry_d;
        end
    end

    assign Program_Counter_Low_Register_Out  = pcl_q;
    assign Program_Counter_High_Register_Out = pch_q;
    assign ABL      = abl_q;
    assign ABH      = abh_q;
    assign PC_Carry = carry_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed and randomized checks of program_counter against a 16-bit arithmetic model.
module tb_program_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] adl = 8'h00;
    logic [7:0] adh = 8'h00;
    logic       adl_pcl = 1'b0;
    logic       adh_pch = 1'b0;
    logic       i_pc = 1'b0;
    logic       adl_abl = 1'b0;
    logic       adh_abh = 1'b0;
    logic [7:0] pcl_out, pch_out, abl_out, abh_out;
    logic       carry_out;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] m_pc = 16'h0000;
    logic [7:0]  m_abl = 8'h00;
    logic [7:0]  m_abh = 8'h00;
    logic        m_carry = 1'b0;

    always #5 clk = ~clk;

    program_counter dut (
        .clk(clk),
        .rst(rst),
        .ADL(adl),
        .ADH(adh),
        .ADL_PCL(adl_pcl),
        .ADH_PCH(adh_pch),
        .I_PC(i_pc),
        .ADL_ABL(adl_abl),
        .ADH_ABH(adh_abh),
        .Program_Counter_Low_Register_Out(pcl_out),
        .Program_Counter_High_Register_Out(pch_out),
        .ABL(abl_out),
        .ABH(abh_out),
        .PC_Carry(carry_out)
    );

    task automatic chk16(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk16({tag, ".pc"}, {pch_out, pcl_out}, m_pc);
        chk16({tag, ".ab"}, {abh_out, abl_out}, {m_abh, m_abl});
        chk16({tag, ".carry"}, {15'h0, carry_out}, {15'h0, m_carry});
    endtask

    task automatic expect_pc(input string tag, input logic [15:0] pc, input logic c);
        chk16({tag, ".pc_const"}, {pch_out, pcl_out}, pc);
        chk16({tag, ".carry_const"}, {15'h0, carry_out}, {15'h0, c});
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare.
    task automatic step(input logic r, input logic lpcl, input logic lpch, input logic inc,
                        input logic labl, input logic labh, input logic [7:0] a_l,
                        input logic [7:0] a_h, input string tag);
        logic [7:0] src_l, src_h;
        rst = r; adl_pcl = lpcl; adh_pch = lpch; i_pc = inc;
        adl_abl = labl; adh_abh = labh; adl = a_l; adh = a_h;
        @(posedge clk);
        if (r) begin
            m_pc = 16'h0000; m_abl = 8'h00; m_abh = 8'h00; m_carry = 1'b0;
        end else begin
            src_l = lpcl ? a_l : m_pc[7:0];
            src_h = lpch ? a_h : m_pc[15:8];
            m_carry = inc && (src_l == 8'hFF);
            m_pc = {src_h, src_l} + {15'h0, inc};
            if (labl) m_abl = a_l;
            if (labh) m_abh = a_h;
        end
        #1;
        check_model(tag);
    endtask

    initial begin
        #2;
        step(1, 1, 1, 1, 1, 1, 8'hAA, 8'h55, "reset");
        expect_pc("reset", 16'h0000, 1'b0);
        chk16("reset.ab_const", {abh_out, abl_out}, 16'h0000);

        step(0, 1, 1, 0, 0, 0, 8'h34, 8'h12, "load");
        expect_pc("load", 16'h1234, 1'b0);
        step(0, 0, 0, 1, 0, 0, 8'h00, 8'h00, "inc1");
        expect_pc("inc1", 16'h1235, 1'b0);
        step(0, 0, 0, 1, 0, 0, 8'h00, 8'h00, "inc2");
        expect_pc("inc2", 16'h1236, 1'b0);
        step(0, 0, 0, 1, 0, 0, 8'h00, 8'h00, "inc3");
        expect_pc("inc3", 16'h1237, 1'b0);

        step(0, 1, 1, 0, 0, 0, 8'hFF, 8'h12, "load12ff");
        step(0, 0, 0, 1, 0, 0, 8'h00, 8'h00, "page_cross");
        expect_pc("page_cross", 16'h1300, 1'b1);
        step(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, "idle");
        expect_pc("idle", 16'h1300, 1'b0);

        step(0, 1, 1, 0, 0, 0, 8'hFF, 8'hFF, "loadffff");
        step(0, 0, 0, 1, 0, 0, 8'h00, 8'h00, "wrap");
        expect_pc("wrap", 16'h0000, 1'b1);

        step(0, 1, 1, 0, 0, 0, 8'h00, 8'h80, "load8000");
        step(0, 0, 0, 1, 1, 1, 8'h00, 8'h80, "fetch");
        expect_pc("fetch", 16'h8001, 1'b0);
        chk16("fetch.ab_const", {abh_out, abl_out}, 16'h8000);

        step(0, 1, 1, 1, 0, 0, 8'hFF, 8'h20, "load_inc");
        expect_pc("load_inc", 16'h2100, 1'b1);
        step(1, 0, 0, 1, 0, 0, 8'h00, 8'h00, "mid_reset");
        expect_pc("mid_reset", 16'h0000, 1'b0);

        for (int i = 0; i < 400; i++) begin
            logic [7:0] r_adl;
            logic [3:0] sel;
            sel = 4'($urandom_range(0, 15));
            case (sel[1:0])
                2'd0: r_adl = m_pc[7:0];
                2'd1: r_adl = 8'hFF;
                default: r_adl = 8'($urandom);
            endcase
            step(($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom),
                 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                 r_adl, (sel[3:2] == 2'd0) ? 8'hFF : 8'($urandom), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
